addsub_acc_serial: RTL and testbench
====================================

ADDSUB_ACC_SERIAL -- requirements
Module: addsub_acc_serial

Interface
REQ-001 The block SHALL have parameter N, default 8, accumulator width in bits; legal values multiples of 4 in the range 4..32.
REQ-002 The block SHALL have parameter D = N/4, a derived constant giving nibble and digit count; it is not user-overridable.
REQ-003 Port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 Port start, input, 1 bit: operation request, sampled only when busy=0.
REQ-006 Port op, input, 2 bits: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-007 Port B, input, N bits: operand, captured at the accept edge.
REQ-008 Port busy, output, 1 bit: high while a nibble-serial ADD/SUB is in progress.
REQ-009 Port done, output, 1 bit: one-cycle completion pulse.
REQ-010 Port ACC, output, N bits: accumulator value.
REQ-011 Port cout, output, 1 bit: ADD carry out of the MSB; SUB borrow (1 when B > ACC, unsigned).
REQ-012 Port ovf, output, 1 bit: two's-complement signed overflow of the last ADD/SUB.
REQ-013 Port HEX, output, 7*D bits: active-low 7-segment patterns; digit i at bits [7i+6:7i] shows ACC[4i+3:4i]; bit 7i+6 drives segment a, bit 7i drives segment g.

Function
REQ-014 States SHALL be IDLE and RUN only; busy=1 exactly when the state is RUN.
REQ-015 Accept edge E0: start=1 and state IDLE at a rising edge; start while busy=1 SHALL be ignored, with no queueing.
REQ-016 LOAD at E0: ACC<=B, cout<=0, ovf<=0, done=1 in the cycle after E0, state stays IDLE.
REQ-017 CLEAR at E0: ACC<=0, cout<=0, ovf<=0, done=1 in the cycle after E0, state stays IDLE.
REQ-018 ADD/SUB at E0: capture A=ACC and B; for SUB use operand ~B; set initial carry to 0 for ADD and 1 for SUB; nibble index <=0; state<=RUN.
REQ-019 In RUN, one 4-bit nibble SHALL be added per cycle, LSB nibble first, with carry rippled in a 1-bit register between nibbles; nibble k is registered at edge E0+k+1.
REQ-020 Partial results SHALL be held in a shadow register; ACC, cout and ovf SHALL stay unchanged during RUN.
REQ-021 At edge E0+D, the block SHALL: update ACC atomically; set cout = final carry for ADD or its inverse for SUB; set ovf = (sign A == sign of the effective operand) and (sign result != sign A); set done=1 for one cycle; set state<=IDLE.
REQ-022 Latency: done SHALL be visible D cycles after E0 for ADD/SUB (2 for N=8) and 1 cycle for LOAD/CLEAR.
REQ-023 Results SHALL wrap modulo 2^N; a carry or borrow SHALL affect only cout.
REQ-024 The block SHALL accept start in the same cycle done=1, giving back-to-back operations with no idle cycle.
REQ-025 Changes to B or op after E0 SHALL have no effect on the operation in flight.
REQ-026 HEX SHALL be a combinational decode of the current ACC with codes 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.

Reset
REQ-027 With reset=1 at an edge, the block SHALL set ACC=0, cout=0, ovf=0, done=0, busy=0, state=IDLE, shadow, carry and index cleared; this takes priority over start.
REQ-028 Reset during RUN SHALL abort the operation with no done pulse; ACC SHALL read 0, not a partial result.
REQ-029 After reset, every HEX digit SHALL read 0000001.

Verification (N=8)
REQ-030 Reset test: hold reset for 2 cycles -> ACC=0x00, busy=0, done=0, cout=0, ovf=0, HEX=0000001 on both digits.
REQ-031 Carry test: LOAD 0x3C, then ADD 0xD5 -> busy high for 2 cycles, done pulse, ACC=0x11, cout=1, ovf=0, HEX digit1=1001111, digit0=1001111.
REQ-032 Borrow test: LOAD 0x10, then SUB 0x20 -> ACC=0xF0, cout=1, ovf=0; then SUB 0x01 -> ACC=0xEF, cout=0.
REQ-033 Overflow test: LOAD 0x7F, ADD 0x01 -> ACC=0x80, cout=0, ovf=1; then back-to-back SUB 0x01 started in the done cycle -> ACC=0x7F, ovf=1.
REQ-034 Ignore and abort test: start ADD 0x05 with op/B changed and start pulsed while busy -> extra start ignored, ACC=old+0x05; start ADD, then assert reset at E0+1 -> no done pulse, ACC=0x00.
REQ-035 CLEAR test: CLEAR after ACC=0xAB -> ACC=0x00 one cycle after E0, done=1 for exactly one cycle, busy stays 0.

Source files
------------

// File: rtl/addsub_acc_serial_if.sv
// Operation request / result bundle for the nibble-serial add/subtract accumulator.
interface addsub_acc_serial_if #(
  parameter int N = 8
);
  localparam int D = N / 4;

  logic           start;
  logic [1:0]     op;
  logic [N-1:0]   B;
  logic           busy;
  logic           done;
  logic [N-1:0]   ACC;
  logic           cout;
  logic           ovf;
  logic [7*D-1:0] HEX;

  modport master (
    output start, op, B,
    input  busy, done, ACC, cout, ovf, HEX
  );

  modport slave (
    input  start, op, B,
    output busy, done, ACC, cout, ovf, HEX
  );
endinterface

// File: rtl/addsub_acc_serial.sv
// Accumulator with single-cycle LOAD/CLEAR and nibble-serial ADD/SUB (one nibble per clock),
// plus an active-low 7-segment decode of the accumulator.
module addsub_acc_serial #(
  parameter int N = 8
) (
  input logic              CLK,
  input logic              reset,
  addsub_acc_serial_if.slave bus
);
  localparam int D  = N / 4;
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_SUB, OP_CLEAR} op_t;

  state_t         state, state_next;
  op_t            op_in;
  logic           accept_arith;
  logic           last;

  logic [N-1:0]   acc_q;
  logic           cout_q, ovf_q, done_q;
  logic [N-1:0]   a_sh, b_sh, shadow, shadow_next;
  logic           carry;
  logic [IW-1:0]  idx;
  logic           a_sign, b_sign, is_sub;
  logic [4:0]     nib_sum;

  assign op_in = op_t'(bus.op);

  // State register
  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept_arith) state_next = RUN;
      RUN:  if (last)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    bus.busy     = (state == RUN);
    accept_arith = (state == IDLE) && bus.start && (op_in == OP_ADD || op_in == OP_SUB);
    last         = (state == RUN) && (idx == IW'(D - 1));
  end

  // Operands shift right a nibble per cycle; the result nibble enters the shadow from the top,
  // so after D cycles the shadow holds the full sum in place.
  always_comb begin
    nib_sum     = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0, carry};
    shadow_next = (shadow >> 4) | (N'(nib_sum[3:0]) << (N - 4));
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      acc_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      shadow <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      is_sub <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (op_in)
              OP_LOAD: begin
                acc_q  <= bus.B;
                cout_q <= 1'b0;
                ovf_q  <= 1'b0;
                done_q <= 1'b1;
              end
              OP_CLEAR: begin
                acc_q  <= '0;
                cout_q <= 1'b0;
                ovf_q  <= 1'b0;
                done_q <= 1'b1;
              end
              default: begin
                is_sub <= (op_in == OP_SUB);
                a_sh   <= acc_q;
                b_sh   <= (op_in == OP_SUB) ? ~bus.B : bus.B;
                a_sign <= acc_q[N-1];
                b_sign <= (op_in == OP_SUB) ? ~bus.B[N-1] : bus.B[N-1];
                carry  <= (op_in == OP_SUB);
                idx    <= '0;
                shadow <= '0;
              end
            endcase
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          carry  <= nib_sum[4];
          shadow <= shadow_next;
          idx    <= idx + IW'(1);
          if (last) begin
            acc_q  <= shadow_next;
            cout_q <= nib_sum[4] ^ is_sub;
            ovf_q  <= (a_sign == b_sign) && (shadow_next[N-1] != a_sign);
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    bus.ACC  = acc_q;
    bus.cout = cout_q;
    bus.ovf  = ovf_q;
    bus.done = done_q;
    bus.HEX  = '1;
    for (int unsigned i = 0; i < D; i++) begin
      bus.HEX[7*i +: 7] = seg7(acc_q[4*i +: 4]);
    end
  end
endmodule

// File: tb/tb_addsub_acc_serial.sv
// Randomized and directed checking of addsub_acc_serial against a transaction-level model.
module tb_addsub_acc_serial;
  localparam int N = 8;
  localparam int D = N / 4;
  localparam logic [1:0] LOAD = 2'd0, ADD = 2'd1, SUB = 2'd2, CLR = 2'd3;

  logic CLK;
  logic reset;

  addsub_acc_serial_if #(.N(N)) bus ();

  addsub_acc_serial #(.N(N)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  function automatic logic [7*D-1:0] hex_of(input longint unsigned v);
    logic [7*D-1:0] h;
    h = '0;
    for (int d = 0; d < D; d++) h[7*d +: 7] = seg_tab[(v >> (4*d)) & 15];
    return h;
  endfunction

  // Transaction-level model: an arithmetic op is computed in full at acceptance and
  // published after D cycles; inputs are ignored while it is pending.
  localparam longint unsigned MOD = 64'd1 << N;
  longint unsigned m_acc, p_acc;
  bit m_cout, m_ovf, m_done, p_cout, p_ovf;
  int m_left;
  bit check_en = 0;

  always @(posedge CLK) begin
    if (reset) begin
      m_acc = 0; m_cout = 0; m_ovf = 0; m_done = 0; m_left = 0;
      check_en = 1;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_acc = p_acc; m_cout = p_cout; m_ovf = p_ovf; m_done = 1;
        end
      end else if (bus.start === 1'b1) begin
        longint unsigned a, b;
        longint signed sa, sb, sr;
        a  = m_acc;
        b  = longint'(bus.B);
        sa = (a >= MOD/2) ? longint'(a) - longint'(MOD) : longint'(a);
        sb = (b >= MOD/2) ? longint'(b) - longint'(MOD) : longint'(b);
        case (bus.op)
          LOAD: begin m_acc = b; m_cout = 0; m_ovf = 0; m_done = 1; end
          CLR:  begin m_acc = 0; m_cout = 0; m_ovf = 0; m_done = 1; end
          ADD: begin
            p_acc = (a + b) % MOD; p_cout = (a + b) >= MOD;
            sr = sa + sb; p_ovf = (sr >= longint'(MOD/2)) || (sr < -longint'(MOD/2));
            m_left = D;
          end
          default: begin
            p_acc = (a + MOD - b) % MOD; p_cout = b > a;
            sr = sa - sb; p_ovf = (sr >= longint'(MOD/2)) || (sr < -longint'(MOD/2));
            m_left = D;
          end
        endcase
      end
    end
  end

  always @(negedge CLK) begin
    if (check_en) begin
      chk("acc",  64'(bus.ACC),  64'(m_acc));
      chk("busy", 64'(bus.busy), 64'(m_left > 0));
      chk("done", 64'(bus.done), 64'(m_done));
      chk("cout", 64'(bus.cout), 64'(m_cout));
      chk("ovf",  64'(bus.ovf),  64'(m_ovf));
      chk("hex",  64'(bus.HEX),  64'(hex_of(m_acc)));
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [N-1:0] b);
    bus.start = 1'b1; bus.op = o; bus.B = b;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int bcyc);
    bit seen;
    seen = 0; bcyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.done === 1'b1) seen = 1;
      else begin
        if (bus.busy === 1'b1) bcyc++;
        step();
      end
    end
    chk("done_timeout", 64'(seen), 64'd1);
  endtask

  int bc;

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.op = LOAD; bus.B = '0;
    step(); step();
    chk("rst_acc",  64'(bus.ACC), 64'h00);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    chk("rst_ovf",  64'(bus.ovf), 64'd0);
    chk("rst_hex",  64'(bus.HEX), 64'(14'b0000001_0000001));
    reset = 1'b0;
    step();

    // Carry
    issue(LOAD, 8'h3C); wait_done(bc);
    issue(ADD, 8'hD5);  wait_done(bc);
    chk("carry_busy_cycles", 64'(bc), 64'd2);
    chk("carry_acc",  64'(bus.ACC), 64'h11);
    chk("carry_cout", 64'(bus.cout), 64'd1);
    chk("carry_ovf",  64'(bus.ovf), 64'd0);
    chk("carry_hex",  64'(bus.HEX), 64'(14'b1001111_1001111));
    step();

    // Borrow
    issue(LOAD, 8'h10); wait_done(bc);
    issue(SUB, 8'h20);  wait_done(bc);
    chk("borrow_acc",  64'(bus.ACC), 64'hF0);
    chk("borrow_cout", 64'(bus.cout), 64'd1);
    chk("borrow_ovf",  64'(bus.ovf), 64'd0);
    issue(SUB, 8'h01);  wait_done(bc);
    chk("borrow2_acc",  64'(bus.ACC), 64'hEF);
    chk("borrow2_cout", 64'(bus.cout), 64'd0);
    step();

    // Overflow, then back-to-back SUB issued in the done cycle
    issue(LOAD, 8'h7F); wait_done(bc);
    issue(ADD, 8'h01);  wait_done(bc);
    chk("ovf_acc",  64'(bus.ACC), 64'h80);
    chk("ovf_cout", 64'(bus.cout), 64'd0);
    chk("ovf_ovf",  64'(bus.ovf), 64'd1);
    issue(SUB, 8'h01);
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done(bc);
    chk("b2b_acc", 64'(bus.ACC), 64'h7F);
    chk("b2b_ovf", 64'(bus.ovf), 64'd1);
    step();

    // Start / op / B changes during RUN are ignored
    issue(ADD, 8'h05);
    bus.start = 1'b1; bus.op = LOAD; bus.B = 8'hFF;
    step();
    bus.start = 1'b0;
    wait_done(bc);
    chk("ignore_acc", 64'(bus.ACC), 64'h84);
    step();

    // Reset at E0+1 aborts without done
    issue(ADD, 8'h05);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_acc",  64'(bus.ACC), 64'h00);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", 64'(bus.done), 64'd0);
      step();
    end

    // CLEAR
    issue(LOAD, 8'hAB); wait_done(bc);
    step();
    issue(CLR, 8'h55);
    chk("clr_acc",  64'(bus.ACC), 64'h00);
    chk("clr_done", 64'(bus.done), 64'd1);
    chk("clr_busy", 64'(bus.busy), 64'd0);
    step();
    chk("clr_done_pulse", 64'(bus.done), 64'd0);
    chk("clr_busy2", 64'(bus.busy), 64'd0);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      reset     = ($urandom_range(0, 63) == 0);
      bus.start = 1'($urandom_range(0, 1));
      bus.op    = 2'($urandom_range(0, 3));
      bus.B     = 8'($urandom);
      step();
    end
    reset = 1'b0; bus.start = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
